// File: rtl/fan_ctrl_pkg.sv
// Shared constants, state encoding and saturation helpers for the fan PI/slew controller.
package fan_ctrl_pkg;

  localparam logic [15:0] Q15_ONE  = 16'h7FFF;
  localparam logic [15:0] Q15_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2
  } fan_state_e;

  // Saturate a signed 20-bit intermediate into the unsigned range [0, hi].
  function automatic logic [15:0] clamp_q15(input logic signed [19:0] v, input logic [15:0] hi);
    logic [15:0] r;
    if (v < 20'sd0) begin
      r = Q15_ZERO;
    end else if (v > $signed({4'b0000, hi})) begin
      r = hi;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [15:0] max_u16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_dac.sv
// Free-running PWM generator; period 2^CTR_W-1 so a full-scale duty holds the output high.
module pwm_dac #(
  parameter int CTR_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CTR_W-1:0] duty,
  output logic             pwm
);

  localparam logic [CTR_W-1:0] CTR_LAST = ~CTR_W'(1);

  logic [CTR_W-1:0] cnt_r;
  logic             pwm_r;

  // Period counter and registered compare output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      pwm_r <= 1'b0;
    end else begin
      cnt_r <= (cnt_r == CTR_LAST) ? '0 : cnt_r + CTR_W'(1);
      pwm_r <= (duty > cnt_r);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/fan_pi_slew_ctrl.sv
// PI temperature loop with anti-windup, demand max-combine, slew limiting and an
// OFF/SPINUP/RUN kick-start FSM driving the fan PWM.
module fan_pi_slew_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter logic [15:0] T_SET_OCC_Q15   = 16'd14564,
  parameter logic [15:0] T_SET_UNOCC_Q15 = 16'd16748,
  parameter logic [15:0] KP_OCC_Q14      = 16'd4,
  parameter logic [15:0] KP_UNOCC_Q14    = 16'd2,
  parameter logic [15:0] KI_OCC_Q14      = 16'd1,
  parameter logic [15:0] KI_UNOCC_Q14    = 16'd1,
  parameter logic [15:0] I_MAX_Q15       = 16'd16384,
  parameter logic [15:0] U_BIAS_Q15      = 16'd1024,
  parameter logic [15:0] DUTY_PIR_Q15    = 16'h6000,
  parameter logic [15:0] U_MIN_Q15       = 16'd4096,
  parameter logic [15:0] U_HYST_Q15      = 16'd1024,
  parameter logic [15:0] SLEW_STEP_Q15   = 16'd1024,
  parameter int          SPINUP_TICKS    = 10,
  parameter int          CTRL_DIV        = 5000000,
  parameter int          PWM_W           = 12
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic [15:0] sample_q15,
  input  logic        sample_vld,
  input  logic        btn_d_pulse,
  input  logic        pir_on,
  input  logic        sw_temp_en,
  input  logic        sw_manual_en,
  input  logic        sw_pir_en,
  output logic        fan_pwm,
  output logic        fan_en,
  output logic [1:0]  fsm_state_dbg,
  output logic [15:0] duty_cmd_q15_dbg,
  output logic [15:0] integ_q15_dbg
);

  localparam int                 DIV_W     = $clog2(CTRL_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CTRL_DIV - 1);
  localparam int                 SPIN_W    = $clog2(SPINUP_TICKS + 1);
  localparam logic [SPIN_W-1:0]  SPIN_LOAD = SPIN_W'(SPINUP_TICKS - 1);
  localparam logic [15:0]        U_OFF_Q15 = U_MIN_Q15 - U_HYST_Q15;
  localparam logic [15+PWM_W-1:0] PWM_FS   = (15 + PWM_W)'((1 << PWM_W) - 1);

  logic [DIV_W-1:0]  tick_cnt_r;
  logic [15:0]       temp_r, integ_r, duty_r;
  logic              manual_r, fan_en_r;
  fan_state_e        state_r;
  logic [SPIN_W-1:0] spin_cnt_r;

  logic               tick_s, occ_s, hold_s;
  logic [15:0]        t_set_s, kp_s, ki_s;
  logic signed [16:0] e_s;
  logic signed [32:0] p_prod_s, i_prod_s, p_shr_s, i_shr_s;
  logic signed [19:0] p_s, i_inc_s, u_raw_s, integ_sum_s;
  logic [15:0]        u_temp_s, integ_nxt_s, target_s, goal_s, diff_s, slew_duty_s;
  logic [15+PWM_W-1:0] pwm_prod_s;
  logic [PWM_W-1:0]   duty_pwm_s;

  assign tick_s  = (tick_cnt_r == DIV_LAST);
  assign occ_s   = sw_pir_en & pir_on;
  assign t_set_s = occ_s ? T_SET_OCC_Q15 : T_SET_UNOCC_Q15;
  assign kp_s    = occ_s ? KP_OCC_Q14 : KP_UNOCC_Q14;
  assign ki_s    = occ_s ? KI_OCC_Q14 : KI_UNOCC_Q14;

  assign e_s         = $signed({temp_r[15], temp_r}) - $signed({t_set_s[15], t_set_s});
  assign p_prod_s    = $signed({{16{e_s[16]}}, e_s}) * $signed({{17{kp_s[15]}}, kp_s});
  assign i_prod_s    = $signed({{16{e_s[16]}}, e_s}) * $signed({{17{ki_s[15]}}, ki_s});
  assign p_shr_s     = p_prod_s >>> 14;
  assign i_shr_s     = i_prod_s >>> 14;
  assign p_s         = p_shr_s[19:0];
  assign i_inc_s     = i_shr_s[19:0];
  assign u_raw_s     = p_s + $signed({4'b0000, integ_r}) + $signed({4'b0000, U_BIAS_Q15});
  assign integ_sum_s = $signed({4'b0000, integ_r}) + i_inc_s;
  // Freeze the integrator while the output is pinned and the error would push it further.
  assign hold_s = ((u_raw_s >= 20'sd32767) && (e_s > 17'sd0)) ||
                  ((u_raw_s <= 20'sd0) && (e_s < 17'sd0));

  // Temperature contribution and next integrator value.
  always_comb begin
    u_temp_s    = Q15_ZERO;
    integ_nxt_s = Q15_ZERO;
    if (sw_temp_en) begin
      u_temp_s    = clamp_q15(u_raw_s, Q15_ONE);
      integ_nxt_s = hold_s ? integ_r : clamp_q15(integ_sum_s, I_MAX_Q15);
    end else begin
      u_temp_s    = Q15_ZERO;
      integ_nxt_s = Q15_ZERO;
    end
  end

  assign target_s = max_u16(max_u16(u_temp_s, occ_s ? DUTY_PIR_Q15 : Q15_ZERO),
                            (sw_manual_en & manual_r) ? Q15_ONE : Q15_ZERO);
  assign goal_s   = max_u16(target_s, U_MIN_Q15);

  // One slew step of duty_r toward the RUN goal.
  always_comb begin
    diff_s      = Q15_ZERO;
    slew_duty_s = duty_r;
    if (goal_s > duty_r) begin
      diff_s      = goal_s - duty_r;
      slew_duty_s = (diff_s > SLEW_STEP_Q15) ? duty_r + SLEW_STEP_Q15 : goal_s;
    end else begin
      diff_s      = duty_r - goal_s;
      slew_duty_s = (diff_s > SLEW_STEP_Q15) ? duty_r - SLEW_STEP_Q15 : goal_s;
    end
  end

  // Tick divider, input capture, integrator and OFF/SPINUP/RUN sequencing.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
      temp_r     <= Q15_ZERO;
      manual_r   <= 1'b0;
      integ_r    <= Q15_ZERO;
      duty_r     <= Q15_ZERO;
      state_r    <= ST_OFF;
      spin_cnt_r <= '0;
      fan_en_r   <= 1'b0;
    end else begin
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + DIV_W'(1);
      if (sample_vld) temp_r <= sample_q15;
      if (btn_d_pulse) manual_r <= ~manual_r;
      if (tick_s) begin
        integ_r <= integ_nxt_s;
        case (state_r)
          ST_OFF: begin
            if (target_s >= U_MIN_Q15) begin
              state_r    <= ST_SPINUP;
              spin_cnt_r <= SPIN_LOAD;
              duty_r     <= Q15_ONE;
              fan_en_r   <= 1'b1;
            end else begin
              duty_r   <= Q15_ZERO;
              fan_en_r <= 1'b0;
            end
          end
          ST_SPINUP: begin
            if (target_s < U_OFF_Q15) begin
              state_r  <= ST_OFF;
              duty_r   <= Q15_ZERO;
              fan_en_r <= 1'b0;
            end else if (spin_cnt_r == '0) begin
              state_r  <= ST_RUN;
              duty_r   <= Q15_ONE;
              fan_en_r <= 1'b1;
            end else begin
              spin_cnt_r <= spin_cnt_r - SPIN_W'(1);
              duty_r     <= Q15_ONE;
              fan_en_r   <= 1'b1;
            end
          end
          ST_RUN: begin
            if (target_s < U_OFF_Q15) begin
              state_r  <= ST_OFF;
              duty_r   <= Q15_ZERO;
              fan_en_r <= 1'b0;
            end else begin
              duty_r   <= slew_duty_s;
              fan_en_r <= 1'b1;
            end
          end
          default: begin
            state_r  <= ST_OFF;
            duty_r   <= Q15_ZERO;
            fan_en_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pwm_prod_s = {{PWM_W{1'b0}}, duty_r[14:0]} * PWM_FS;
  assign duty_pwm_s = pwm_prod_s[15 +: PWM_W];

  pwm_dac #(.CTR_W(PWM_W)) u_pwm_dac (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .duty  (duty_pwm_s),
    .pwm   (fan_pwm)
  );

  assign fan_en           = fan_en_r;
  assign fsm_state_dbg    = state_r;
  assign duty_cmd_q15_dbg = duty_r;
  assign integ_q15_dbg    = integ_r;

endmodule
